uo_out_capture_tx: RTL and testbench



---
 rtl/uo_out_capture_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_uo_out_capture_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uo_out_capture_tx.sv
// Captures each new stable value of the tile's uo_out bus into a small FIFO and
// serialises it on a UART-style tx pin. Define PARITY_EN to add an even-parity bit.
module uo_out_capture_tx #(
    parameter int CLK_DIV       = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    uo_out,
    input  logic                          clear_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]       s1_q, s2_q;
    logic [7:0]       cand_q, cand_d;
    logic [7:0]       last_q, last_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic [STB_W-1:0] run;
    logic             capture;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, push, pop;
    logic [7:0]       head;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            last_q <= '0;
            stb_q  <= '0;
        end else begin
            s1_q   <= uo_out;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            last_q <= last_d;
            stb_q  <= stb_d;
        end
    end

    // The stable count includes the cycle in which the candidate is loaded.
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        cand_d  = cand_q;
        stb_d   = stb_q;
        last_d  = last_q;
        capture = 1'b0;
        run     = (s2_q == cand_q) ? stb_q + 1'b1 : STB_W'(1);
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            stb_d  = STB_W'(1);
        end else if (cand_q != last_q) begin
            stb_d = run;
        end
        if ((s2_q != last_q) && (run == STB_W'(STABLE_CYCLES))) begin
            capture = 1'b1;
            last_d  = s2_q;
        end
    end

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = capture && (!full || pop);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (clear_ovf)
            ovf_d = 1'b0;
        if (capture && full && !pop)
            ovf_d = 1'b1;
    end

    // NOTE: storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        bit_end = (div_q == DIV_W'(CLK_DIV - 1));
        if (state_q != IDLE)
            div_d = bit_end ? '0 : div_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                    div_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_end)
                    state_d = STOP;
            end
`endif
            STOP: begin
                // Back-to-back frames: reload straight into START with no idle gap.
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PARITY_EN
        if (pop)
            par_d = ^head;
`endif

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uo_out_capture_tx.sv
// Self-checking bench for uo_out_capture_tx: directed scenarios plus randomized
// value/hold sequences checked against a capture-rule model and a tx frame decoder.
module tb_uo_out_capture_tx;

    localparam int CLK_DIV       = 4;
    localparam int FIFO_DEPTH    = 4;
    localparam int STABLE_CYCLES = 2;
`ifdef PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    uo_out = 8'hFF;
    logic          clear_ovf = 1'b0;
    logic          tx, busy, overflow;
    logic [CW-1:0] fifo_count;

    int            checks   = 0;
    int            failures = 0;
    bit            mon_en   = 1'b0;
    logic [7:0]    exp_q[$];

    uo_out_capture_tx #(
        .CLK_DIV      (CLK_DIV),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uo_out    (uo_out),
        .clear_ovf (clear_ovf),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_wait(input string tag, input int budget);
        int n = 0;
        repeat (STABLE_CYCLES + 4) @(negedge clk);
        while ((busy !== 1'b0 || fifo_count !== '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    // Frame decoder: samples each bit once per bit-time, aligned from the start bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b0 && tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
`ifdef PARITY_EN
                repeat (CLK_DIV) @(negedge clk);
                check("mon_parity", 32'(tx), 32'(^b));
`endif
                repeat (CLK_DIV) @(negedge clk);
                check("mon_stop", 32'(tx), 32'd1);
                check("mon_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("mon_byte", 32'(b), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NBITS-1:0] fb;
        logic [7:0]       data;
        logic [7:0]       last_cap, run_val, v;
        int               run_len, h, nseg, busy_n, rises, n;
        logic             any, prev;

        // Reset state, then the 0xFF frame caused by last_captured clearing to 0x00.
        rst = 1'b1;
        uo_out = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        mon_en = 1'b1;
        exp_q.push_back(8'hFF);
        rst = 1'b0;
        idle_wait("rst_ff_drain", 4 * FRAME);
        check("rst_ff_seen", 32'(exp_q.size()), 32'd0);

        // Single frame 0xA5 after priming 0x00: latency and exact waveform.
        exp_q.push_back(8'h00);
        uo_out = 8'h00;
        idle_wait("prime00_drain", 4 * FRAME);
        data = 8'hA5;
`ifdef PARITY_EN
        fb = {1'b1, ^data, data, 1'b0};
`else
        fb = {1'b1, data, 1'b0};
`endif
        exp_q.push_back(data);
        uo_out = data;
        repeat (4) @(negedge clk);
        check("a5_pre_tx", 32'(tx), 32'd1);
        check("a5_pre_busy", 32'(busy), 32'd0);
        busy_n = 0;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                check($sformatf("a5_bit%0d", b), 32'(tx), 32'(fb[b]));
                if (busy === 1'b1) busy_n++;
            end
        end
        check("a5_busy_len", 32'(busy_n), 32'(FRAME));
        any = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            any = any | busy | ~tx;
        end
        check("a5_no_second_frame", 32'(any), 32'd0);
        check("a5_seen", 32'(exp_q.size()), 32'd0);

        // Glitch: one-cycle 0x3C between 0x00 levels must never be captured.
        exp_q.push_back(8'h00);
        uo_out = 8'h00;
        idle_wait("prime00b_drain", 4 * FRAME);
        uo_out = 8'h3C;
        @(negedge clk);
        uo_out = 8'h00;
        any = 1'b0;
        repeat (FRAME) begin
            @(negedge clk);
            any = any | busy | (fifo_count != '0) | ~tx;
        end
        check("glitch_no_activity", 32'(any), 32'd0);

        // Burst 0x01..0x06: five frames back-to-back, 0x06 dropped, overflow sticky.
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        busy_n = 0;
        rises  = 0;
        prev   = busy;
        for (int i = 1; i <= 6; i++) begin
            uo_out = 8'(i);
            repeat (4) begin
                @(negedge clk);
                if (busy === 1'b1) busy_n++;
                if (busy === 1'b1 && prev !== 1'b1) rises++;
                prev = busy;
            end
        end
        check("burst_count_full", 32'(fifo_count), 32'(FIFO_DEPTH));
        check("burst_ovf_set", 32'(overflow), 32'd1);
        n = 0;
        while ((busy !== 1'b0 || fifo_count !== '0) && n < 8 * FRAME) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (busy === 1'b1 && prev !== 1'b1) rises++;
            prev = busy;
            n++;
        end
        check("burst_drained", 32'(n < 8 * FRAME), 32'd1);
        check("burst_busy_len", 32'(busy_n), 32'(5 * FRAME));
        check("burst_single_busy_run", 32'(rises), 32'd1);
        check("burst_frames_seen", 32'(exp_q.size()), 32'd0);
        check("burst_ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("burst_ovf_cleared", 32'(overflow), 32'd0);

        // Reset during DATA bit 3 with a byte still queued.
        mon_en = 1'b0;
        uo_out = 8'h52;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_started", 32'(busy), 32'd1);
        uo_out = 8'h77;
        repeat (4 * CLK_DIV + 1) @(negedge clk);
        check("midrst_bit3", 32'(tx), 32'd0);
        check("midrst_queued", 32'(fifo_count), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        uo_out = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        any = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            any = any | busy | ~tx | (fifo_count != '0);
        end
        check("midrst_silent", 32'(any), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        mon_en = 1'b1;

        // Randomized value/hold runs: a run of >= STABLE_CYCLES cycles of a value
        // different from the last captured one yields exactly one frame.
        last_cap = 8'h00;
        run_val  = 8'h00;
        run_len  = 1000;
        for (int r = 0; r < 8; r++) begin
            nseg = $urandom_range(1, 5);
            for (int s = 0; s < nseg; s++) begin
                v = ($urandom_range(0, 3) == 0) ? run_val : 8'($urandom_range(0, 255));
                h = $urandom_range(1, 6);
                if (v == run_val) begin
                    run_len += h;
                end else begin
                    run_val = v;
                    run_len = h;
                end
                if (run_len >= STABLE_CYCLES && run_val != last_cap) begin
                    exp_q.push_back(run_val);
                    last_cap = run_val;
                end
                uo_out = v;
                repeat (h) @(negedge clk);
            end
            // The final value stays on the bus while the queue drains.
            if (run_val != last_cap) begin
                exp_q.push_back(run_val);
                last_cap = run_val;
            end
            run_len = 1000;
            idle_wait($sformatf("rnd%0d_drain", r), 8 * FRAME);
            check($sformatf("rnd%0d_frames", r), 32'(exp_q.size()), 32'd0);
            check($sformatf("rnd%0d_ovf", r), 32'(overflow), 32'd0);
        end

        check("final_tx_idle", 32'(tx), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
